tinker_fetch: RTL and testbench

Instruction fetch unit for the Tinker core. It is the producer side of the 32-bit instruction word that the decoder consumes. It maintains the PC and issues word reads to instruction memory over a req/ack handshake. Fetched words are buffered in a small FIFO and presented to the decode stage with a valid/ready handshake, together with their PC. It also accepts PC redirects from branch resolution.

---
 rtl/tinker_pkg.sv | 7 +
 rtl/tinker_fetch_fifo.sv | 60 ++++++
 rtl/tinker_fetch.sv | 110 +++++++++++
 tb/tb_tinker_fetch.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinker_pkg.sv
// tinker_pkg: shared types and constants for the Tinker instruction fetch unit.
package tinker_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W = 64;
    localparam logic [ADDR_W-1:0] TINKER_RESET_PC = 64'h2000;
    typedef enum logic [1:0] {FETCH, DROP, HALT} fetch_state_t;
endpackage

// File: rtl/tinker_fetch_fifo.sv
// tinker_fetch_fifo: synchronous {word, pc} FIFO with flush; DEPTH must be a power of two >= 2.
module tinker_fetch_fifo
    import tinker_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [INSTR_W-1:0]     push_word,
    input  logic [ADDR_W-1:0]      push_pc,
    output logic [INSTR_W-1:0]     head_word,
    output logic [ADDR_W-1:0]      head_pc,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    logic [INSTR_W-1:0] word_q [DEPTH];
    logic [INSTR_W-1:0] word_d [DEPTH];
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic [ADDR_W-1:0] pc_d [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PW:0] count_q, count_d;

    always_comb begin
        word_d = word_q;
        pc_d = pc_q;
        if (push && !flush) begin
            word_d[wr_q] = push_word;
            pc_d[wr_q] = push_pc;
        end
        rd_d = flush ? '0 : rd_q + PW'(pop);
        wr_d = flush ? '0 : wr_q + PW'(push);
        count_d = flush ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= '0;
            wr_q <= '0;
            count_q <= '0;
        end else begin
            rd_q <= rd_d;
            wr_q <= wr_d;
            count_q <= count_d;
        end
        word_q <= word_d;
        pc_q <= pc_d;
    end

    // head reads as zero while empty so stale slots never leak to decode
    assign empty = count_q == '0;
    assign full = count_q == (PW+1)'(DEPTH);
    assign count = count_q;
    assign head_word = empty ? '0 : word_q[rd_q];
    assign head_pc = empty ? '0 : pc_q[rd_q];
endmodule

// File: rtl/tinker_fetch.sv
// tinker_fetch: PC/request sequencer feeding a small instruction FIFO toward decode.
// Define TINKER_FETCH_PERF_EN to add the perf_fetched/perf_dropped counters.
module tinker_fetch
    import tinker_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = TINKER_RESET_PC,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
`ifdef TINKER_FETCH_PERF_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_dropped,
`endif
    output logic               fetch_fault
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    fetch_state_t state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
    logic req_q, req_d, fault_q, fault_d;
    logic ack, busy, push, pop, full, empty;
    logic [CW-1:0] count, count_nxt;

    always_comb begin
        ack = req_q && mem_ack;
        busy = req_q && !mem_ack;
        pop = !empty && instr_ready && !redirect_valid;
        push = ack && state_q == FETCH && !redirect_valid && (!full || pop);
        count_nxt = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
        pc_d = redirect_valid ? redirect_pc : pc_q + (push ? 64'd4 : 64'd0);
        fault_d = redirect_valid ? |redirect_pc[1:0] : fault_q;
        // an in-flight request must complete (and be discarded) before HALT or a new fetch
        state_d = redirect_valid ? (busy ? DROP : fault_d ? HALT : FETCH)
                : (state_q == DROP && ack) ? (fault_q ? HALT : FETCH) : state_q;
        req_d = busy || (state_d == FETCH && count_nxt < CW'(FIFO_DEPTH));
        addr_d = busy ? addr_q : pc_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q <= RESET_PC;
            addr_q <= RESET_PC;
            req_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            addr_q <= addr_d;
            req_q <= req_d;
            fault_q <= fault_d;
        end
    end

    tinker_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_word (mem_rdata),
        .push_pc   (addr_q),
        .head_word (instruction),
        .head_pc   (instr_pc),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign mem_req = req_q;
    assign mem_addr = addr_q;
    assign instr_valid = !empty;
    assign fetch_fault = fault_q;

`ifdef TINKER_FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d, dropped_q, dropped_d;
    logic [32:0] fetched_sum, dropped_sum;

    always_comb begin
        fetched_sum = {1'b0, fetched_q} + 33'(push);
        dropped_sum = {1'b0, dropped_q}
                    + 33'(redirect_valid ? count + CW'(ack) : CW'(state_q == DROP && ack));
        fetched_d = fetched_sum[32] ? '1 : fetched_sum[31:0];
        dropped_d = dropped_sum[32] ? '1 : dropped_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= '0;
            dropped_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            dropped_q <= dropped_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_dropped = dropped_q;
`endif
endmodule

// File: tb/tb_tinker_fetch.sv
// tb_tinker_fetch: scoreboard bench for tinker_fetch with a latency-programmable memory model.
module tb_tinker_fetch;
    import tinker_pkg::*;

    typedef struct {
        logic [31:0] word;
        logic [63:0] pc;
    } entry_t;

    typedef struct {
        int          lat;
        bit          alt;
        logic [63:0] start;
        int          n;
        int          max_steps;
    } rec_t;

    localparam logic [31:0] BEEF = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_req, mem_ack, instr_valid, instr_ready, redirect_valid, fetch_fault;
    logic [63:0] mem_addr, instr_pc, redirect_pc;
    logic [31:0] mem_rdata, instruction;
`ifdef TINKER_FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_dropped;
`endif

    tinker_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef TINKER_FETCH_PERF_EN
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped),
`endif
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, age = 0, lat = 1, npops = 0, fetched = 0, dropped = 0, beef_seen = 0;
    bit hold = 0, rdy = 1, alt = 0, redir = 0, dropping = 0, last_ack = 0, last_valid = 0;
    logic [63:0] redir_pc = '0, exp_pc = 64'h2000;
    entry_t sb[$];

    function automatic logic [31:0] data_fn(input logic [63:0] a);
        return 32'hC8421000 + (a[31:0] - 32'h2000);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // one clock: sample outputs, drive memory/decode/redirect inputs, update scoreboard
    task automatic step();
        entry_t e;
        bit ack, rdy_now;
        @(posedge clk);
        #1;
        cyc++;
        rdy_now = alt ? cyc[0] : rdy;
        ack = (mem_req === 1'b1) && !hold && (age >= lat);
        mem_ack = ack;
        mem_rdata = !ack ? 32'h0 : (dropping || redir) ? BEEF : data_fn(mem_addr);
        instr_ready = rdy_now;
        redirect_valid = redir;
        redirect_pc = redir_pc;
        last_ack = ack;
        last_valid = instr_valid && rdy_now;
        if (instr_valid && instruction == BEEF) beef_seen++;
        if (redir) begin
            dropped += sb.size() + int'(ack);
            sb.delete();
            dropping = mem_req && !ack;
            exp_pc = redir_pc;
        end else begin
            if (instr_valid && rdy_now) begin
                npops++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_valid: got instr_pc 0x%0h, expected no instruction", instr_pc);
                end else begin
                    e = sb.pop_front();
                    chk("instr_word", 64'(instruction), 64'(e.word));
                    chk("instr_pc", instr_pc, e.pc);
                end
            end
            if (ack && dropping) begin
                dropping = 0;
                dropped++;
            end else if (ack) begin
                chk("mem_addr", mem_addr, exp_pc);
                e.word = data_fn(mem_addr);
                e.pc = mem_addr;
                sb.push_back(e);
                exp_pc += 64'd4;
                fetched++;
            end
        end
        age = (mem_req && !ack) ? age + 1 : 0;
        redir = 0;
    endtask

    task automatic run_pops(input int n, input int max_steps, input string name);
        int start;
        bit done;
        start = npops;
        done = 0;
        for (int s = 0; s < max_steps && !done; s++) begin
            step();
            done = (npops - start) >= n;
        end
        chk(name, 64'(done), 64'd1);
    endtask

    task automatic wait_req(input int max_steps, input string name);
        for (int s = 0; s < max_steps && !mem_req; s++) step();
        chk(name, 64'(mem_req), 64'd1);
    endtask

    initial begin
        rec_t recs[5];
        int nreq;
        recs[0] = '{0, 1'b0, 64'h5000, 8, 9};
        recs[1] = '{1, 1'b0, 64'h6000, 6, 16};
        recs[2] = '{2, 1'b0, 64'h7000, 4, 18};
        recs[3] = '{0, 1'b1, 64'h8000, 6, 40};
        recs[4] = '{3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 4, 60};
        mem_ack = 0;
        mem_rdata = '0;
        instr_ready = 0;
        redirect_valid = 0;
        redirect_pc = '0;

        repeat (3) step();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'h2000);
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_instruction", 64'(instruction), 64'd0);
        chk("rst_instr_pc", instr_pc, 64'd0);
        chk("rst_fetch_fault", 64'(fetch_fault), 64'd0);

        reset = 0;
        step();
        chk("first_req", 64'(mem_req), 64'd1);
        chk("first_addr", mem_addr, 64'h2000);
        step();
        chk("first_ack", 64'(last_ack), 64'd1);
        step();
        chk("latency_valid", 64'(instr_valid), 64'd1);
        chk("latency_word", 64'(instruction), 64'hC8421000);
        run_pops(2, 20, "stream_lat1");

        // stall decode: FIFO fills with two words, then requests stop
        rdy = 0;
        redir = 1;
        redir_pc = 64'h2000;
        step();
        repeat (10) step();
        chk("fill_req_off", 64'(mem_req), 64'd0);
        chk("fill_valid", 64'(instr_valid), 64'd1);
        chk("fill_head_pc", instr_pc, 64'h2000);
        chk("fill_head_word", 64'(instruction), 64'(data_fn(64'h2000)));
        hold = 1;
        rdy = 1;
        run_pops(2, 6, "drain");
        wait_req(10, "resume_req");
        chk("resume_addr", mem_addr, 64'h2008);

        // redirect while 0x2008 is outstanding; its late ack must be discarded
        redir = 1;
        redir_pc = 64'h3000;
        step();
        step();
        chk("flush_valid", 64'(instr_valid), 64'd0);
        chk("drop_req_held", 64'(mem_req), 64'd1);
        chk("drop_addr_held", mem_addr, 64'h2008);
        step();
        hold = 0;
        lat = 0;
        step();
        chk("drop_ack", 64'(last_ack), 64'd1);
        step();
        chk("redir_req", 64'(mem_req), 64'd1);
        chk("redir_addr", mem_addr, 64'h3000);
        run_pops(4, 10, "post_drop");

        // misaligned redirect with a request in flight: drain, then halt
        hold = 1;
        wait_req(5, "pre_fault_req");
        redir = 1;
        redir_pc = 64'h3002;
        step();
        step();
        chk("fault_set", 64'(fetch_fault), 64'd1);
        chk("fault_drain_req", 64'(mem_req), 64'd1);
        hold = 0;
        step();
        nreq = 0;
        repeat (6) begin
            step();
            nreq += int'(mem_req);
        end
        chk("halt_no_req", 64'(nreq), 64'd0);
        chk("halt_valid", 64'(instr_valid), 64'd0);
        chk("halt_fault", 64'(fetch_fault), 64'd1);
        redir = 1;
        redir_pc = 64'h4000;
        step();
        step();
        chk("fault_clear", 64'(fetch_fault), 64'd0);
        chk("resume4000_req", 64'(mem_req), 64'd1);
        chk("resume4000_addr", mem_addr, 64'h4000);
        run_pops(3, 10, "stream_4000");

        // redirect coinciding with an ack and a pop
        redir = 1;
        redir_pc = 64'h9000;
        step();
        chk("same_cycle_ack", 64'(last_ack), 64'd1);
        chk("same_cycle_pop", 64'(last_valid), 64'd1);
        step();
        chk("same_cycle_flush", 64'(instr_valid), 64'd0);
        chk("same_cycle_req", 64'(mem_req), 64'd1);
        chk("same_cycle_addr", mem_addr, 64'h9000);

        for (int i = 0; i < 5; i++) begin
            lat = recs[i].lat;
            alt = recs[i].alt;
            hold = 0;
            redir = 1;
            redir_pc = recs[i].start;
            step();
            run_pops(recs[i].n, recs[i].max_steps, $sformatf("rec%0d_done", i));
        end

        alt = 0;
        hold = 1;
        rdy = 0;
        step();
        step();
        chk("beef_hidden", 64'(beef_seen), 64'd0);
`ifdef TINKER_FETCH_PERF_EN
        chk("perf_fetched", 64'(perf_fetched), 64'(fetched));
        chk("perf_dropped", 64'(perf_dropped), 64'(dropped));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
